// File: rtl/rtio_sched_pkg.sv
// Shared types and helpers for the RTIO timed event scheduler.
package rtio_sched_pkg;

  localparam int unsigned TS_WIDTH       = 64;
  localparam int unsigned EVT_DATA_WIDTH = 64;
  localparam int unsigned LATE_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [TS_WIDTH-1:0]       ts;
    logic [EVT_DATA_WIDTH-1:0] data;
  } rtio_event_t;

  // Saturating increment for the late-event counter.
  function automatic logic [LATE_CNT_WIDTH-1:0] sat_inc(input logic [LATE_CNT_WIDTH-1:0] v);
    logic [LATE_CNT_WIDTH-1:0] r;
    r = (v == {LATE_CNT_WIDTH{1'b1}}) ? v : v + LATE_CNT_WIDTH'(1);
    return r;
  endfunction

endpackage

// File: rtl/rtio_event_fifo.sv
// First-word-fall-through event buffer with occupancy count and single-cycle flush.
module rtio_event_fifo #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [ADDR_WIDTH:0]   count
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_push_c;
  logic                  do_pop_c;

  // Flush overrides any same-cycle push or pop.
  always_comb begin
    do_push_c = push && (count_q != (ADDR_WIDTH+1)'(DEPTH)) && !flush;
    do_pop_c  = pop && (count_q != '0) && !flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rtio_event_scheduler.sv
// Timed event dispatcher: issues each buffered event when the timestamp counter
// reaches its time, drops late events and halts until flushed.
module rtio_event_scheduler
  import rtio_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [TS_WIDTH-1:0]       counter,
  input  logic                      auto_start,
  input  logic                      flush,
  input  logic                      clear_status,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [TS_WIDTH-1:0]       wr_timestamp,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [TS_WIDTH-1:0]       out_timestamp,
  output logic                      underflow,
  output logic [LATE_CNT_WIDTH-1:0] late_count,
  output logic [FIFO_ADDR_WIDTH:0]  fifo_count,
  output logic                      busy
);

  localparam int unsigned EVT_WIDTH = TS_WIDTH + DATA_WIDTH;

  sched_state_t              state_q, state_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic [TS_WIDTH-1:0]       out_ts_q, out_ts_d;
  logic                      underflow_q, underflow_d;
  logic [LATE_CNT_WIDTH-1:0] late_count_q, late_count_d;

  logic [EVT_WIDTH-1:0]      head;
  logic [TS_WIDTH-1:0]       head_ts;
  logic [DATA_WIDTH-1:0]     head_data;
  logic                      head_valid_c;
  logic                      push_c;
  logic                      pop_c;
  logic                      dispatch_c;
  logic                      late_c;

  rtio_event_fifo #(
    .WIDTH      (EVT_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push_c),
    .pop   (pop_c),
    .din   ({wr_timestamp, wr_data}),
    .dout  (head),
    .count (fifo_count)
  );

  assign head_ts      = head[EVT_WIDTH-1 -: TS_WIDTH];
  assign head_data    = head[DATA_WIDTH-1:0];
  assign head_valid_c = (fifo_count != '0);
  assign wr_ready     = (fifo_count != (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign push_c       = wr_valid && wr_ready;

  // Head compare, FSM and status update; a late event outranks clear_status.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_ts_d     = out_ts_q;
    underflow_d  = clear_status ? 1'b0 : underflow_q;
    late_count_d = clear_status ? '0 : late_count_q;
    dispatch_c   = 1'b0;
    late_c       = 1'b0;

    if ((state_q == RUN) && head_valid_c && !flush) begin
      dispatch_c = (head_ts == counter);
      late_c     = (head_ts < counter);
    end
    pop_c = dispatch_c || late_c;

    if (dispatch_c) begin
      out_valid_d = 1'b1;
      out_data_d  = head_data;
      out_ts_d    = head_ts;
    end
    if (late_c) begin
      underflow_d  = 1'b1;
      late_count_d = sat_inc(late_count_d);
    end

    case (state_q)
      IDLE:    if (auto_start) state_d = RUN;
      RUN: begin
        if (late_c)           state_d = HALT;
        else if (!auto_start) state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ts_q     <= '0;
      underflow_q  <= 1'b0;
      late_count_q <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ts_q     <= out_ts_d;
      underflow_q  <= underflow_d;
      late_count_q <= late_count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_timestamp = out_ts_q;
  assign underflow     = underflow_q;
  assign late_count    = late_count_q;
  assign busy          = (state_q == RUN) && head_valid_c;

endmodule

// File: tb/tb_rtio_event_scheduler.sv
// Scoreboard bench for rtio_event_scheduler: expected dispatches queued at write time.
module tb_rtio_event_scheduler;

  typedef struct packed {
    logic [63:0] ts;
    logic [63:0] data;
  } exp_evt_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] counter = '0;
  logic        auto_start = 1'b0;
  logic        flush = 1'b0;
  logic        clear_status = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_timestamp = '0;
  logic [63:0] wr_data = '0;
  logic        out_valid;
  logic [63:0] out_data;
  logic [63:0] out_timestamp;
  logic        underflow;
  logic [15:0] late_count;
  logic [4:0]  fifo_count;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  bit          cnt_en = 1'b0;
  logic [63:0] cnt_seen = '0;
  exp_evt_t    sb[$];

  rtio_event_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .counter       (counter),
    .auto_start    (auto_start),
    .flush         (flush),
    .clear_status  (clear_status),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_timestamp  (wr_timestamp),
    .wr_data       (wr_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_timestamp (out_timestamp),
    .underflow     (underflow),
    .late_count    (late_count),
    .fifo_count    (fifo_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] mkdata(input logic [63:0] ts);
    return ts ^ 64'hA5A5_0000_5A5A_0000;
  endfunction

  // Counter value the DUT compared against at the most recent edge.
  always @(posedge clk) cnt_seen <= counter;

  // Output monitor: every strobe must match the oldest expected event, one cycle late.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_evt_t e;
        e = sb.pop_front();
        chk("out_timestamp", out_timestamp, e.ts);
        chk("out_data", out_data, e.data);
        chk("dispatch_latency", out_timestamp, cnt_seen);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cnt_en) counter = counter + 64'd1;
    end
  endtask

  task automatic wr_evt(input logic [63:0] ts, input bit exp_out);
    for (int i = 0; i < 64 && !wr_ready; i++) step();
    if (!wr_ready) chk("wr_ready_wait", 64'(wr_ready), 64'd1);
    wr_valid     = 1'b1;
    wr_timestamp = ts;
    wr_data      = mkdata(ts);
    if (exp_out) sb.push_back('{ts: ts, data: mkdata(ts)});
    step();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    step(2);
    reset = 1'b0;
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ts", out_timestamp, 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_late_count", 64'(late_count), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // 1: in-order dispatch, back-to-back timestamps
    counter    = 64'd90;
    cnt_en     = 1'b1;
    auto_start = 1'b1;
    wr_evt(64'd105, 1'b1);
    wr_evt(64'd106, 1'b1);
    wr_evt(64'd110, 1'b1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_fifo_count", 64'(fifo_count), 64'd3);
    drain(40, "t1_drain");
    chk("t1_underflow", 64'(underflow), 64'd0);
    chk("t1_fifo_empty", 64'(fifo_count), 64'd0);

    // 2: late event halts; queued event waits for flush
    counter = 64'd200;
    wr_evt(64'd150, 1'b0);
    step(2);
    chk("t2_underflow", 64'(underflow), 64'd1);
    chk("t2_late_count", 64'(late_count), 64'd1);
    chk("t2_fifo_after_drop", 64'(fifo_count), 64'd0);
    wr_evt(64'd300, 1'b0);
    step(20);
    chk("t2_halt_fifo", 64'(fifo_count), 64'd1);
    chk("t2_halt_busy", 64'(busy), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t2_flush_fifo", 64'(fifo_count), 64'd0);
    chk("t2_flush_underflow", 64'(underflow), 64'd1);
    chk("t2_flush_late", 64'(late_count), 64'd1);
    auto_start = 1'b0;
    step();
    auto_start = 1'b1;
    step();
    counter = 64'd290;
    wr_evt(64'd300, 1'b1);
    drain(40, "t2_drain");

    // 3: fill to full, held write enters once the first event dispatches
    auto_start = 1'b0;
    step(2);
    cnt_en  = 1'b0;
    counter = 64'd400;
    for (int i = 0; i < 16; i++) wr_evt(64'd500 + 64'(i), 1'b1);
    chk("t3_full_ready", 64'(wr_ready), 64'd0);
    chk("t3_full_count", 64'(fifo_count), 64'd16);
    wr_valid     = 1'b1;
    wr_timestamp = 64'd516;
    wr_data      = mkdata(64'd516);
    sb.push_back('{ts: 64'd516, data: mkdata(64'd516)});
    step(3);
    chk("t3_held_count", 64'(fifo_count), 64'd16);
    auto_start = 1'b1;
    step();
    counter = 64'd500;
    cnt_en  = 1'b1;
    step();
    chk("t3_ready_after_pop", 64'(wr_ready), 64'd1);
    chk("t3_count_after_pop", 64'(fifo_count), 64'd15);
    step();
    wr_valid = 1'b0;
    chk("t3_push_pop_count", 64'(fifo_count), 64'd15);
    drain(60, "t3_drain");

    // 4: event passes while disabled, turns late on re-enable
    auto_start   = 1'b0;
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("t4_clr_underflow", 64'(underflow), 64'd0);
    chk("t4_clr_late", 64'(late_count), 64'd0);
    counter = 64'd40;
    wr_evt(64'd50, 1'b0);
    step(19);
    chk("t4_counter", counter, 64'd60);
    chk("t4_idle_fifo", 64'(fifo_count), 64'd1);
    chk("t4_idle_underflow", 64'(underflow), 64'd0);
    auto_start = 1'b1;
    step(3);
    chk("t4_underflow", 64'(underflow), 64'd1);
    chk("t4_late_count", 64'(late_count), 64'd1);
    chk("t4_fifo_count", 64'(fifo_count), 64'd0);

    // 5: flush with 5 queued; clear_status coinciding with a late event
    cnt_en  = 1'b0;
    counter = 64'd65;
    for (int i = 0; i < 5; i++) wr_evt(64'd1000 + 64'(i), 1'b0);
    chk("t5_queued", 64'(fifo_count), 64'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush_fifo", 64'(fifo_count), 64'd0);
    chk("t5_flush_underflow", 64'(underflow), 64'd1);
    chk("t5_flush_late", 64'(late_count), 64'd1);
    wr_evt(64'd10, 1'b0);
    step(2);
    chk("t5_late_two", 64'(late_count), 64'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    wr_evt(64'd20, 1'b0);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("t5_late_wins_uf", 64'(underflow), 64'd1);
    chk("t5_late_wins_cnt", 64'(late_count), 64'd1);
    chk("t5_late_wins_fifo", 64'(fifo_count), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // 6: reset on the matching cycle suppresses the strobe
    step();
    counter = 64'd700;
    wr_evt(64'd705, 1'b0);
    chk("t6_busy", 64'(busy), 64'd1);
    counter = 64'd705;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_fifo", 64'(fifo_count), 64'd0);
    chk("t6_underflow", 64'(underflow), 64'd0);
    chk("t6_late", 64'(late_count), 64'd0);
    chk("t6_out_ts", out_timestamp, 64'd0);
    chk("t6_out_data", out_data, 64'd0);
    chk("t6_wr_ready", 64'(wr_ready), 64'd1);
    step(2);
    chk("t6_no_late_strobe", 64'(out_valid), 64'd0);
    chk("t6_idle_fifo", 64'(fifo_count), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
